noc_resp_arbiter: RTL and testbench
===================================

// Module: noc_resp_arbiter
// PURPOSE
//  Response-path merger downstream of the per-device response FIFOs (dev 0x40, 0x41) in the switch.
//  Pops whole packets from two 9-bit {ctl,data} FIFOs and drives the single noc_from_dev bus.
//  - Packets are never interleaved.
//  - NOP (ctl=1, data=0) is driven when idle.
//  Grants a source only when its FIFO holds a complete packet, so a packet never underruns mid-stream.
// PARAMETERS
//  CNT_W   4   width of each per-source complete-packet counter
// PORTS
//  clk               in   1  clock, rising edge
//  reset             in   1  synchronous, active-high
//  wen0 / wen1       in   1  FIFO write strobes, snooped for packet counting
//  din0 / din1       in   9  FIFO write data {ctl,data}, snooped
//  empty0 / empty1   in   1  FIFO empty
//  dout0 / dout1     in   9  FIFO head {ctl,data}, show-ahead (valid when !empty)
//  ren0 / ren1       out  1  FIFO pop, combinational, one-cycle pulse per entry
//  noc_from_dev_ctl  out  1  registered response ctl
//  noc_from_dev_data out  8  registered response data
//  grant             out  2  registered: 01 = src0 active, 10 = src1 active, 00 = idle
//  err               out  1  sticky protocol-error flag; cleared only by reset
// BEHAVIOUR
//  Packet format in FIFO (all byte values hex):
//  - cmd: ctl=1, data!=0
//  - then N>=0 data bytes: ctl=0
//  - then terminator: ctl=1, data=00
//  Reset values:
//  - noc_from_dev_ctl=1, noc_from_dev_data=00, grant=00, err=0, ren*=0
//  - pkt_cnt0 = pkt_cnt1 = 0, last=1 (so src0 wins first), state=IDLE
//  Packet counters:
//  - inc when wen_i && din_i==9'h100; dec when ren_i && dout_i==9'h100.
//  - Inc and dec in the same cycle: count unchanged.
//  - Inc at max (all ones): count holds and err is set.
//  FSM states: IDLE, FWD.
//  IDLE:
//  - Output NOP.
//  - Eligible source: pkt_cnt_i>0 && !empty_i && dout_i[8] && dout_i[7:0]!=0.
//  - Pick an eligible source per the arbitration rule, pop its cmd (ren_i=1), set sel, go FWD.
//    grant updates with the registered output.
//  - Head of a source with pkt_cnt_i>0 is not a cmd: pop and discard one entry per cycle, set err.
//    That source is not granted that cycle.
//  FWD, head of sel:
//  - ctl=0: pop and forward.
//  - 9'h100: pop and forward as NOP, update last=sel, go IDLE.
//  - cmd (missing terminator): do not pop, drive NOP, set err, go IDLE.
//  - sel empty (impossible while counted; defensive): drive NOP, set err, go IDLE.
//  Latency:
//  - Output register updates the cycle after a pop, i.e. bus(N+1) = dout_sel(N).
//  - Back-to-back packets are separated by exactly one NOP: the forwarded terminator.
//  ren is asserted only when the matching empty is 0; never both ren0 and ren1 in one cycle.
//  Reset asserted mid-packet:
//  - Next cycle, outputs are at reset values and the FSM is IDLE.
//  - The FIFOs are reset by the same reset; no partial packet resumes.
// CONFIGURATION
//  NOC_ARB_RR_EN defined:
//  - Round-robin at packet granularity.
//  - Both eligible: grant the source != last.
//  NOC_ARB_RR_EN undefined:
//  - Fixed priority; src0 (dev 0x40) wins whenever eligible.
//  - last is still maintained but unused.
// TESTING
//  1. Reset, no traffic -> bus holds ctl=1 data=00, grant=00, ren0=ren1=0, err=0.
//  2. src0 writes 1A,05,06,00 (ctl 1,0,0,1) -> bus emits 1A,05,06,NOP one cycle after each pop;
//     pkt_cnt0 goes 1 then 0.
//  3. Both FIFOs hold one complete packet at once:
//     RR_EN -> src0 packet, one NOP, then src1 packet; fixed -> same order.
//     Repeat with last=0: RR_EN gives src1 first, fixed still src0 first.
//  4. src1 cmd 2B and one data byte written, terminator delayed 5 cycles ->
//     no grant until terminator written, then 2B,77,NOP emitted.
//  5. Head at IDLE is stray data byte 9'h033 with pkt_cnt0=1 -> entry popped and dropped,
//     err=1, following packet forwarded intact.
//  6. Reset asserted in FWD after 2 bytes of a 4-byte packet ->
//     next cycle NOP, grant=00, err=0, pkt counters 0.

Source files
------------

// File: rtl/noc_resp_arbiter.sv
// noc_resp_arbiter
// Merges two show-ahead response FIFOs (dev 0x40 -> src0, dev 0x41 -> src1) onto the
// noc_from_dev bus one whole packet at a time. A source is granted only while its FIFO
// holds at least one complete packet, counted by snooping FIFO writes, so a packet that
// has started on the bus never runs dry. NOP (ctl=1, data=00) is driven when idle.
// Build option: define NOC_ARB_RR_EN for packet-level round-robin; when it is undefined,
// src0 has fixed priority.
module noc_resp_arbiter #(
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wen0,
    input  logic       wen1,
    input  logic [8:0] din0,
    input  logic [8:0] din1,
    input  logic       empty0,
    input  logic       empty1,
    input  logic [8:0] dout0,
    input  logic [8:0] dout1,
    output logic       ren0,
    output logic       ren1,
    output logic       noc_from_dev_ctl,
    output logic [7:0] noc_from_dev_data,
    output logic [1:0] grant,
    output logic       err
);

    localparam logic       ST_IDLE = 1'b0;
    localparam logic       ST_FWD  = 1'b1;
    // The idle NOP and the packet terminator share one encoding.
    localparam logic [8:0] NOP     = 9'h100;

    logic             state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;
    logic             err_q, err_d;
    logic [8:0]       out_q, out_d;
    logic [1:0]       grant_q, grant_d;

    logic       is_cmd0, is_cmd1;
    logic       elig0, elig1;
    logic       stray0, stray1;
    logic       pick1;
    logic [8:0] sel_head;
    logic       sel_empty;
    logic       pop0, pop1;
    logic       proto_err;
    logic       inc0, inc1, dec0, dec1;
    logic       ovf0, ovf1;

    // Saturating up/down count; simultaneous inc and dec cancel out.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic             inc,
                                                  input logic             dec);
        if (inc && !dec) begin
            return (&cnt) ? cnt : cnt + CNT_W'(1);
        end
        if (dec && !inc && (cnt != '0)) begin
            return cnt - CNT_W'(1);
        end
        return cnt;
    endfunction

    // Classify both FIFO heads and choose which eligible source an idle arbiter grants.
    always_comb begin
        is_cmd0   = dout0[8] && (dout0[7:0] != 8'h00);
        is_cmd1   = dout1[8] && (dout1[7:0] != 8'h00);
        elig0     = (pkt_cnt0_q != '0) && !empty0 && is_cmd0;
        elig1     = (pkt_cnt1_q != '0) && !empty1 && is_cmd1;
        stray0    = (pkt_cnt0_q != '0) && !empty0 && !is_cmd0;
        stray1    = (pkt_cnt1_q != '0) && !empty1 && !is_cmd1;
        sel_head  = sel_q ? dout1 : dout0;
        sel_empty = sel_q ? empty1 : empty0;
`ifdef NOC_ARB_RR_EN
        // Both eligible: take the source that did not send the previous packet.
        pick1     = elig1 && (!elig0 || !last_q);
`else
        pick1     = elig1 && !elig0;
`endif
    end

    // Packet FSM: grant on a counted cmd, forward until the terminator, bail out on bad framing.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        out_d     = NOP;
        grant_d   = 2'b00;
        pop0      = 1'b0;
        pop1      = 1'b0;
        proto_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (stray0) begin
                    // Counted packet but the head is not a cmd: drop one entry per cycle.
                    pop0      = 1'b1;
                    proto_err = 1'b1;
                end else if (stray1) begin
                    pop1      = 1'b1;
                    proto_err = 1'b1;
                end else if (elig0 || elig1) begin
                    sel_d   = pick1;
                    pop0    = !pick1;
                    pop1    = pick1;
                    out_d   = pick1 ? dout1 : dout0;
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    state_d = ST_FWD;
                end
            end
            ST_FWD: begin
                if (sel_empty) begin
                    // Cannot happen while the count is right; recover to idle.
                    proto_err = 1'b1;
                    state_d   = ST_IDLE;
                end else if (!sel_head[8]) begin
                    pop0    = !sel_q;
                    pop1    = sel_q;
                    out_d   = sel_head;
                    grant_d = sel_q ? 2'b10 : 2'b01;
                end else if (sel_head[7:0] == 8'h00) begin
                    // Terminator goes out as the NOP separating this packet from the next.
                    pop0    = !sel_q;
                    pop1    = sel_q;
                    grant_d = sel_q ? 2'b10 : 2'b01;
                    last_d  = sel_q;
                    state_d = ST_IDLE;
                end else begin
                    // A new cmd where the terminator belongs: leave it queued and abort.
                    proto_err = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Track complete packets per FIFO from terminators written in and popped out.
    always_comb begin
        inc0       = wen0 && (din0 == NOP);
        inc1       = wen1 && (din1 == NOP);
        dec0       = pop0 && (dout0 == NOP);
        dec1       = pop1 && (dout1 == NOP);
        pkt_cnt0_d = cnt_next(pkt_cnt0_q, inc0, dec0);
        pkt_cnt1_d = cnt_next(pkt_cnt1_q, inc1, dec1);
        ovf0       = inc0 && !dec0 && (&pkt_cnt0_q);
        ovf1       = inc1 && !dec1 && (&pkt_cnt1_q);
        err_d      = err_q || proto_err || ovf0 || ovf1;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values.
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            last_q     <= 1'b1;
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
            err_q      <= 1'b0;
            out_q      <= NOP;
            grant_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
            err_q      <= err_d;
            out_q      <= out_d;
            grant_q    <= grant_d;
        end
    end

    assign ren0              = pop0;
    assign ren1              = pop1;
    assign noc_from_dev_ctl  = out_q[8];
    assign noc_from_dev_data = out_q[7:0];
    assign grant             = grant_q;
    assign err               = err_q;

endmodule

// File: tb/tb_noc_resp_arbiter.sv
// tb_noc_resp_arbiter
// Drives noc_resp_arbiter from two show-ahead FIFO fixtures and checks the bus against
// packet-level expectations: per-source byte streams, packet order, one NOP between
// back-to-back packets, no stalls inside a packet, error flag and reset behaviour.
module tb_noc_resp_arbiter;

    localparam logic [8:0] NOP = 9'h100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wen0 = 1'b0;
    logic       wen1 = 1'b0;
    logic [8:0] din0 = 9'h000;
    logic [8:0] din1 = 9'h000;
    logic       empty0, empty1;
    logic [8:0] dout0, dout1;
    logic       ren0, ren1;
    logic       ctl;
    logic [7:0] data;
    logic [1:0] grant;
    logic       err;

    noc_resp_arbiter #(.CNT_W(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .wen0              (wen0),
        .wen1              (wen1),
        .din0              (din0),
        .din1              (din1),
        .empty0            (empty0),
        .empty1            (empty1),
        .dout0             (dout0),
        .dout1             (dout1),
        .ren0              (ren0),
        .ren1              (ren1),
        .noc_from_dev_ctl  (ctl),
        .noc_from_dev_data (data),
        .grant             (grant),
        .err               (err)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO fixtures, depth 64, cleared by the same reset as the arbiter.
    logic [8:0] mem0 [64];
    logic [8:0] mem1 [64];
    logic [6:0] wp0 = '0, rp0 = '0, wp1 = '0, rp1 = '0;

    assign empty0 = (wp0 == rp0);
    assign empty1 = (wp1 == rp1);
    assign dout0  = mem0[rp0[5:0]];
    assign dout1  = mem1[rp1[5:0]];

    always @(posedge clk) begin
        if (reset) begin
            wp0 <= '0;
            rp0 <= '0;
            wp1 <= '0;
            rp1 <= '0;
        end else begin
            if (wen0) begin
                mem0[wp0[5:0]] <= din0;
                wp0 <= wp0 + 7'd1;
            end
            if (wen1) begin
                mem1[wp1[5:0]] <= din1;
                wp1 <= wp1 + 7'd1;
            end
            if (ren0) rp0 <= rp0 + 7'd1;
            if (ren1) rp1 <= rp1 + 7'd1;
        end
    end

    typedef struct {
        int         cyc;
        logic [1:0] g;
        logic [8:0] v;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wcyc;
    int          idx;
    ent_t        bus_log[$];
    logic [10:0] exp_q[$];
    logic [8:0]  pkt_a[$];
    logic [8:0]  pkt_b[$];
    logic [8:0]  w0[$], w1[$], g0[$], g1[$];
    int          p0, p1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample 1 ns after the rising edge, check pop rules, log granted bus beats.
    task automatic tick();
        ent_t e;
        @(posedge clk);
        #1;
        cyc++;
        check("ren_exclusive", int'(ren0 && ren1), 0);
        check("ren_only_nonempty", int'((ren0 && empty0) || (ren1 && empty1)), 0);
        if (grant != 2'b00) begin
            e.cyc = cyc;
            e.g   = grant;
            e.v   = {ctl, data};
            bus_log.push_back(e);
        end
    endtask

    task automatic clear_logs();
        bus_log.delete();
        exp_q.delete();
    endtask

    task automatic push_exp(input logic [1:0] g, input bit use_b);
        if (use_b) begin
            foreach (pkt_b[i]) exp_q.push_back({g, pkt_b[i]});
        end else begin
            foreach (pkt_a[i]) exp_q.push_back({g, pkt_a[i]});
        end
    endtask

    // Write pkt_a to src0 and pkt_b to src1, aligned so both end on the same edge.
    task automatic write_pkts();
        int la = pkt_a.size();
        int lb = pkt_b.size();
        int l  = (la > lb) ? la : lb;
        for (int k = 0; k < l; k++) begin
            int ia = k - (l - la);
            int ib = k - (l - lb);
            wen0 = (ia >= 0);
            din0 = (ia >= 0) ? pkt_a[ia] : 9'h000;
            wen1 = (ib >= 0);
            din1 = (ib >= 0) ? pkt_b[ib] : 9'h000;
            tick();
        end
        wen0 = 1'b0;
        wen1 = 1'b0;
    endtask

    // Run until the arbiter is idle with nothing to pop, within a cycle budget.
    task automatic drain(input string tag, input int budget);
        bit done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            tick();
            done = (grant == 2'b00) && !ren0 && !ren1;
        end
        check({tag, "_drain_done"}, int'(done), 1);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, bus_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < bus_log.size(); i++) begin
            check($sformatf("%s_ent%0d", tag, i), int'({bus_log[i].g, bus_log[i].v}), int'(exp_q[i]));
            if (i > 0 && bus_log[i-1].v != NOP)
                check($sformatf("%s_nostall%0d", tag, i), bus_log[i].cyc, bus_log[i-1].cyc + 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, no traffic: idle NOP, nothing granted or popped.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("t1_ctl", int'(ctl), 1);
        check("t1_data", int'(data), 0);
        check("t1_grant", int'(grant), 0);
        check("t1_ren0", int'(ren0), 0);
        check("t1_ren1", int'(ren1), 0);
        check("t1_err", int'(err), 0);
        check("t1_last", int'(dut.last_q), 1);

        // Single src0 packet 1A,05,06,00.
        clear_logs();
        pkt_a = '{9'h11A, 9'h005, 9'h006, 9'h100};
        for (int i = 0; i < 4; i++) begin
            wen0 = 1'b1;
            din0 = pkt_a[i];
            tick();
            if (i < 3) check("t2_no_early_pop", int'(ren0), 0);
        end
        wen0 = 1'b0;
        wcyc = cyc;
        check("t2_cnt_one", int'(dut.pkt_cnt0_q), 1);
        check("t2_pop_cmd", int'(ren0), 1);
        drain("t2", 20);
        check("t2_cnt_zero", int'(dut.pkt_cnt0_q), 0);
        push_exp(2'b01, 1'b0);
        check_log("t2");
        if (bus_log.size() > 0) check("t2_first_beat_cyc", bus_log[0].cyc, wcyc + 1);
        check("t2_idle_ctl", int'(ctl), 1);
        check("t2_idle_data", int'(data), 0);

        // src1 packet whose terminator arrives five cycles late.
        clear_logs();
        pkt_b = '{9'h12B, 9'h077, 9'h100};
        wen1 = 1'b1;
        din1 = 9'h12B;
        tick();
        din1 = 9'h077;
        tick();
        wen1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_grant", int'(grant), 0);
            check("t4_hold_ren1", int'(ren1), 0);
        end
        wen1 = 1'b1;
        din1 = 9'h100;
        tick();
        wen1 = 1'b0;
        drain("t4", 20);
        push_exp(2'b10, 1'b1);
        check_log("t4");

        // Stray data byte at the head of a counted FIFO: dropped, err set, packet intact.
        clear_logs();
        check("t5_err_pre", int'(err), 0);
        pkt_a = '{9'h033, 9'h11C, 9'h0AA, 9'h100};
        pkt_b.delete();
        write_pkts();
        check("t5_discard_pop", int'(ren0), 1);
        drain("t5", 20);
        check("t5_err", int'(err), 1);
        pkt_a = '{9'h11C, 9'h0AA, 9'h100};
        push_exp(2'b01, 1'b0);
        check_log("t5");

        // Reset in the middle of a forwarded packet.
        clear_logs();
        pkt_a = '{9'h11D, 9'h011, 9'h022, 9'h100};
        write_pkts();
        for (int n = 0; n < 10 && bus_log.size() < 2; n++) tick();
        check("t6_two_beats_out", bus_log.size(), 2);
        reset = 1'b1;
        tick();
        check("t6_ctl", int'(ctl), 1);
        check("t6_data", int'(data), 0);
        check("t6_grant", int'(grant), 0);
        check("t6_err", int'(err), 0);
        check("t6_cnt0", int'(dut.pkt_cnt0_q), 0);
        check("t6_cnt1", int'(dut.pkt_cnt1_q), 0);
        reset = 1'b0;
        repeat (3) begin
            tick();
            check("t6_no_resume_grant", int'(grant), 0);
            check("t6_no_resume_bus", int'({ctl, data}), int'(NOP));
        end

        // Both sources ready at once right after reset: src0 first in either mode.
        clear_logs();
        pkt_a = '{9'h141, 9'h0A1, 9'h100};
        pkt_b = '{9'h142, 9'h0B1, 9'h0B2, 9'h100};
        write_pkts();
        drain("t3a", 30);
        push_exp(2'b01, 1'b0);
        push_exp(2'b10, 1'b1);
        check_log("t3a");
        if (bus_log.size() == 7) check("t3a_one_nop", bus_log[3].cyc, bus_log[2].cyc + 1);

        // src0 sends alone (last becomes src0), then both ready again.
        clear_logs();
        pkt_a = '{9'h143, 9'h100};
        pkt_b.delete();
        write_pkts();
        drain("t3b_solo", 20);
        push_exp(2'b01, 1'b0);
        pkt_a = '{9'h144, 9'h0C1, 9'h100};
        pkt_b = '{9'h145, 9'h100};
        write_pkts();
        drain("t3b", 30);
`ifdef NOC_ARB_RR_EN
        push_exp(2'b10, 1'b1);
        push_exp(2'b01, 1'b0);
        idx = 2 + pkt_b.size();
`else
        push_exp(2'b01, 1'b0);
        push_exp(2'b10, 1'b1);
        idx = 2 + pkt_a.size();
`endif
        check_log("t3b");
        if (bus_log.size() == 7) check("t3b_one_nop", bus_log[idx].cyc, bus_log[idx-1].cyc + 1);

        // Counter saturation: src1 receives 16 terminators while src0 holds the bus.
        clear_logs();
        check("t7_err_pre", int'(err), 0);
        pkt_a.delete();
        pkt_a.push_back(9'h150);
        for (int k = 0; k < 30; k++) pkt_a.push_back({1'b0, 8'(k + 1)});
        pkt_a.push_back(9'h100);
        pkt_b.delete();
        write_pkts();
        for (int k = 0; k < 16; k++) begin
            wen1 = 1'b1;
            din1 = NOP;
            tick();
            if (k == 14) begin
                check("t7_cnt_at_max", int'(dut.pkt_cnt1_q), 15);
                check("t7_err_before_ovf", int'(err), 0);
            end
        end
        wen1 = 1'b0;
        check("t7_cnt_held", int'(dut.pkt_cnt1_q), 15);
        check("t7_err_ovf", int'(err), 1);
        drain("t7", 200);
        push_exp(2'b01, 1'b0);
        check_log("t7");
        check("t7_cnt1_drained", int'(dut.pkt_cnt1_q), 0);
        check("t7_uncounted_left", int'(empty1), 0);

        // Random traffic on both sources; each source's stream must come out unchanged.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_logs();
        for (int p = 0; p < 8; p++) begin
            w0.push_back(NOP | 9'($urandom_range(255, 1)));
            repeat ($urandom_range(3)) w0.push_back({1'b0, 8'($urandom)});
            w0.push_back(NOP);
            w1.push_back(NOP | 9'($urandom_range(255, 1)));
            repeat ($urandom_range(3)) w1.push_back({1'b0, 8'($urandom)});
            w1.push_back(NOP);
        end
        p0 = 0;
        p1 = 0;
        for (int n = 0; n < 2000 && (p0 < w0.size() || p1 < w1.size()); n++) begin
            wen0 = (p0 < w0.size()) && ($urandom_range(1) == 1);
            din0 = wen0 ? w0[p0] : 9'h000;
            if (wen0) p0++;
            wen1 = (p1 < w1.size()) && ($urandom_range(1) == 1);
            din1 = wen1 ? w1[p1] : 9'h000;
            if (wen1) p1++;
            tick();
        end
        wen0 = 1'b0;
        wen1 = 1'b0;
        drain("rnd", 500);
        foreach (bus_log[i]) begin
            if (bus_log[i].g == 2'b01) g0.push_back(bus_log[i].v);
            else if (bus_log[i].g == 2'b10) g1.push_back(bus_log[i].v);
            else check("rnd_grant_onehot", int'(bus_log[i].g), 1);
            if (i > 0 && bus_log[i-1].v != NOP) begin
                check("rnd_no_interleave", int'(bus_log[i].g), int'(bus_log[i-1].g));
                check("rnd_no_stall", bus_log[i].cyc, bus_log[i-1].cyc + 1);
            end
        end
        check("rnd_src0_len", g0.size(), w0.size());
        check("rnd_src1_len", g1.size(), w1.size());
        for (int i = 0; i < w0.size() && i < g0.size(); i++)
            check($sformatf("rnd_src0_ent%0d", i), int'(g0[i]), int'(w0[i]));
        for (int i = 0; i < w1.size() && i < g1.size(); i++)
            check($sformatf("rnd_src1_ent%0d", i), int'(g1[i]), int'(w1[i]));
        check("rnd_err", int'(err), 0);
        check("rnd_cnt0", int'(dut.pkt_cnt0_q), 0);
        check("rnd_cnt1", int'(dut.pkt_cnt1_q), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
